// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit. Sequences one instruction through
// FETCH/DECODE and an opcode-specific tail of 1-3 states, with memory
// wait-state handshaking, a memory-timeout watchdog and illegal-opcode trapping.
module multicycle_controller #(
  parameter bit          ENABLE_JALR     = 1'b1,
  parameter bit          ENABLE_LUI      = 1'b1,
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned MEM_TIMEOUT     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       instr_retire,
  output logic       halted,
  output logic [1:0] err_cause
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // The watchdog counter only has to reach MEM_TIMEOUT-1.
  localparam int unsigned      CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit               WD_EN   = (MEM_TIMEOUT > 0);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic [1:0]       err_next;
  logic             pc_update, branch, illegal, wait_state, timeout;

  // State, watchdog counter and sticky error cause; synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      err_cause <= ERR_NONE;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      err_cause <= err_next;
    end
  end

  // Next-state and control outputs for the current state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_next   = state;
    mem_req      = 1'b0;
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    instr_retire = 1'b0;
    halted       = 1'b0;
    pc_update    = 1'b0;
    branch       = 1'b0;
    illegal      = 1'b0;

    wait_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    timeout    = WD_EN && wait_state && !mem_ready && (wait_cnt == CNT_MAX);

    unique case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut <- OldPC + imm: the branch/JAL target.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_JAL:            state_next = S_JAL;
          OP_BR:             state_next = S_BEQ;
          OP_JALR: if (ENABLE_JALR) state_next = S_JALR; else illegal = 1'b1;
          OP_LUI:  if (ENABLE_LUI)  state_next = S_LUI;  else illegal = 1'b1;
          default:           illegal    = 1'b1;
        endcase
        if (illegal) state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = 2'b01;
        reg_write    = 1'b1;
        instr_retire = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req      = 1'b1;
        adr_src      = 1'b1;
        mem_write    = 1'b1;
        instr_retire = mem_ready;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write    = 1'b1;
        instr_retire = 1'b1;
        state_next   = S_FETCH;
      end
      S_JAL: begin
        // PC <- ALUOut while the ALU forms the link value OldPC + 4.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a    = 2'b10;
        alu_op       = 2'b01;
        branch       = 1'b1;
        instr_retire = 1'b1;
        state_next   = S_FETCH;
      end
      S_JALR: begin
        // ALUOut <- rs1 + imm, then reuse the JAL state to jump and link.
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = S_JAL;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        state_next = S_ALUWB;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    if (timeout) state_next = S_HALT;

    pc_write = pc_update | (branch & branch_cond);

    // Counter runs only while a wait state is stalled on memory.
    wait_cnt_next = (wait_state && !mem_ready && (state_next == state)) ? wait_cnt + 1'b1 : '0;

    // First error wins and sticks until reset.
    err_next = err_cause;
    if (err_cause == ERR_NONE) begin
      if (illegal)      err_next = ERR_ILLEGAL;
      else if (timeout) err_next = ERR_TIMEOUT;
    end

    if (reset) begin
      mem_req      = 1'b0;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      instr_retire = 1'b0;
      halted       = 1'b0;
    end
  end

  // Immediate format selected directly from the opcode.
  always_comb begin
    case (op)
      OP_STORE: imm_src = 3'b001;
      OP_BR:    imm_src = 3'b010;
      OP_JAL:   imm_src = 3'b011;
      OP_LUI:   imm_src = 3'b100;
      default:  imm_src = 3'b000;
    endcase
  end

endmodule
